ahb_arbiter: RTL and testbench
==============================

// Module: ahb_arbiter
// PURPOSE
//  AHB bus arbiter sharing one AHB slave path among up to 16 masters, such as bfm_ahb instances.
//  Samples HBUSREQ/HLOCK per master and the muxed HTRANS/HBURST/HREADY/HRESP.
//  Drives a registered one-hot HGRANT plus HMASTER/HMASTER_D select codes for the address and wdata muxes.
//  Keeps fixed-length bursts and locked sequences intact.
// PARAMETERS
//  NUM_MASTERS     2   number of masters, 1..16
//  DEFAULT_MASTER  0   granted when nobody requests; reset owner
//  ROUND_ROBIN     1   1: rotating priority starting at owner+1; 0: fixed, master 0 highest
// PORTS
//  HCLK       in   1    bus clock
//  HRESETn    in   1    asynchronous active-low reset
//  HBUSREQ    in   N    per-master bus request
//  HLOCK      in   N    per-master lock request
//  HTRANS     in   2    muxed transfer type (IDLE=0 BUSY=1 NONSEQ=2 SEQ=3)
//  HBURST     in   3    muxed burst type (SINGLE=0 INCR=1 WRAP4/INCR4=2/3 WRAP8/INCR8=4/5 WRAP16/INCR16=6/7)
//  HREADY     in   1    bus ready
//  HRESP      in   2    OKAY=0 ERROR=1 RETRY=2 SPLIT=3
//  HGRANT     out  N    one-hot grant, registered
//  HMASTER    out  4    address-phase owner index
//  HMASTER_D  out  4    data-phase owner index (HWDATA mux select)
//  HMASTLOCK  out  1    current address phase is locked
// BEHAVIOUR
//  Reset (async, HRESETn=0):
//  - HGRANT = 1<<DEFAULT_MASTER; HMASTER = HMASTER_D = DEFAULT_MASTER; HMASTLOCK = 0; beats_left = 0.
//  Owner = index of the set HGRANT bit. All state updates occur only on a posedge with HREADY=1; HREADY=0 freezes everything.
//  Beat counter:
//  - Accepted NONSEQ with burst length L = 4/8/16: beats_left <= L-1.
//  - Accepted SEQ: beats_left <= beats_left-1.
//  - IDLE, SINGLE, INCR or non-OKAY response: beats_left <= 0.
//  rearb_ok requires HREADY=1 && HLOCK[owner]=0, plus one of:
//  - HTRANS=IDLE.
//  - NONSEQ with HBURST in {SINGLE,INCR}.
//  - SEQ with HBURST=INCR.
//  - SEQ with beats_left=1 (last beat of a fixed burst).
//  - HRESP in {RETRY,SPLIT} (2nd response cycle).
//  - HRESP=ERROR.
//  HTRANS=BUSY never re-arbitrates, except in the HRESP cases above.
//  Arbitration (rearb_ok=1):
//  - Candidate set = HBUSREQ.
//  - ROUND_ROBIN=1: winner is the first set bit scanning owner+1, owner+2, ... mod N; the owner may win again only if it is the sole requester.
//  - ROUND_ROBIN=0: lowest index wins.
//  - No requests: winner = DEFAULT_MASTER.
//  - HGRANT <= onehot(winner) at that edge.
//  Handover: the new master samples HGRANT&HREADY at the next edge and drives its first address one cycle later.
//  - A master switch therefore costs 1 bubble cycle, during which the old owner drives IDLE (legal AHB).
//  Pipelining (each edge with HREADY=1):
//  - HMASTER <= owner.
//  - HMASTLOCK <= HLOCK[owner].
//  - HMASTER_D <= HMASTER.
//  RETRY/SPLIT: treated identically. The master is not masked and will be re-granted when it re-requests; SPLIT masking is out of scope.
//  Simultaneous events: a lock asserted in the same cycle as rearb_ok wins, and the grant is held. A request dropped mid-burst does not end the burst early.
//  Reset mid-burst: immediate return to reset values; the bench must not expect burst completion.
//  HGRANT stays one-hot at all times; an all-zero or multi-bit grant is a bug. Same rule for out-of-range N inputs.
// TESTING
//  - Reset: HRESETn low 3 cycles, no requests -> HGRANT=01, HMASTER=0, HMASTER_D=0, HMASTLOCK=0.
//  - Idle handoff: M1 requests, M0 IDLE, HREADY=1 -> HGRANT=10 next edge; HMASTER=1 one edge later.
//  - Burst hold: M0 INCR8 in progress, M1 requests at beat 3 -> grant moves to M1 only at the edge of SEQ beat 8 (beats_left=1).
//  - Wait states: HREADY=0 for 4 cycles mid-INCR4 -> HGRANT, HMASTER and beats_left are unchanged until HREADY=1.
//  - Lock and round-robin: M1 holds HLOCK=1 with requests on M0 and M2 -> no switch and HMASTLOCK=1. After release (RR), winner is M2, then M0.
//  - Response/fixed-priority: RETRY on beat 2 of WRAP4 -> re-arbitration at the 2nd RETRY cycle. ROUND_ROBIN=0 with requests on M0 and M1 -> M0 always wins.

Source files
------------

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
//
// Shares a single AHB slave path among up to 16 masters. The arbiter keeps
// fixed-length bursts (4/8/16 beats) and locked sequences intact. When a
// re-arbitration point is reached, it picks the next owner by rotating or
// fixed priority.
//
// Parameters
//   NUM_MASTERS     number of masters, 1..16
//   DEFAULT_MASTER  owner at reset and whenever nobody requests
//   ROUND_ROBIN     1: rotating priority starting at owner+1
//                   0: fixed priority, master 0 highest
//
// Ports
//   HCLK        bus clock
//   HRESETn     asynchronous active-low reset
//   HBUSREQ     per-master bus request
//   HLOCK       per-master lock request
//   HTRANS      muxed transfer type   (IDLE/BUSY/NONSEQ/SEQ)
//   HBURST      muxed burst type
//   HREADY      bus ready; low freezes all arbiter state
//   HRESP       muxed slave response  (OKAY/ERROR/RETRY/SPLIT)
//   HGRANT      registered one-hot grant
//   HMASTER     address-phase owner index (address mux select)
//   HMASTER_D   data-phase owner index (HWDATA mux select)
//   HMASTLOCK   current address phase is locked
// ---------------------------------------------------------------------------
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int ROUND_ROBIN    = 1
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [3:0]             HMASTER,
  output logic [3:0]             HMASTER_D,
  output logic                   HMASTLOCK
);

  // An out-of-range default master would leave the reset grant all-zero,
  // so it falls back to master 0.
  localparam int DEF_IDX = (DEFAULT_MASTER >= 0 && DEFAULT_MASTER < NUM_MASTERS) ?
                           DEFAULT_MASTER : 0;
  localparam logic [3:0]             DEF_CODE  = 4'(DEF_IDX);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEF_IDX;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  localparam logic [2:0] BU_SINGLE = 3'd0;
  localparam logic [2:0] BU_INCR   = 3'd1;

  localparam logic [1:0] RSP_OKAY  = 2'd0;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [NUM_MASTERS-1:0] hgrant_q,     hgrant_d;
  logic [3:0]             hmaster_q,    hmaster_d;
  logic [3:0]             hmaster_dp_q, hmaster_dp_d;
  logic                   hmastlock_q,  hmastlock_d;
  logic [3:0]             beats_left_q, beats_left_d;

  // -------------------------------------------------------------------------
  // Current owner and its lock request
  // -------------------------------------------------------------------------
  logic [3:0] owner;
  logic       owner_lock;

  // The grant is one-hot, so OR-ing the indices of set bits yields the owner.
  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hgrant_q[i]) begin
        owner = owner | 4'(i);
      end
    end
  end

  assign owner_lock = |(HLOCK & hgrant_q);

  // -------------------------------------------------------------------------
  // Beat counter: remaining beats of a fixed-length burst
  // -------------------------------------------------------------------------
  logic [3:0] burst_last;

  // Counter value loaded on NONSEQ: burst length minus one.
  // SINGLE and INCR load 0 because they have no fixed end.
  always_comb begin
    case (HBURST)
      3'd2, 3'd3: burst_last = 4'd3;
      3'd4, 3'd5: burst_last = 4'd7;
      3'd6, 3'd7: burst_last = 4'd15;
      default:    burst_last = 4'd0;
    endcase
  end

  always_comb begin
    beats_left_d = beats_left_q;
    if (HREADY) begin
      if (HRESP != RSP_OKAY) begin
        beats_left_d = '0;
      end else begin
        case (HTRANS)
          TR_NONSEQ: beats_left_d = burst_last;
          TR_SEQ:    beats_left_d = (beats_left_q != 4'd0) ? beats_left_q - 4'd1 : 4'd0;
          TR_IDLE:   beats_left_d = '0;
          default:   beats_left_d = beats_left_q;   // BUSY: burst paused
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Re-arbitration point
  // -------------------------------------------------------------------------
  logic rearb_term;
  logic rearb_ok;

  // Any non-OKAY response ends ownership:
  //   ERROR aborts the burst.
  //   RETRY/SPLIT are seen here in their second (HREADY=1) cycle.
  // BUSY alone never qualifies.
  always_comb begin
    rearb_term = 1'b0;
    if (HTRANS == TR_IDLE) begin
      rearb_term = 1'b1;
    end
    if (HTRANS == TR_NONSEQ && (HBURST == BU_SINGLE || HBURST == BU_INCR)) begin
      rearb_term = 1'b1;
    end
    if (HTRANS == TR_SEQ && (HBURST == BU_INCR || beats_left_q == 4'd1)) begin
      rearb_term = 1'b1;
    end
    if (HRESP != RSP_OKAY) begin
      rearb_term = 1'b1;
    end
  end

  // A held lock always wins over an otherwise valid arbitration point.
  assign rearb_ok = HREADY && !owner_lock && rearb_term;

  // -------------------------------------------------------------------------
  // Winner selection
  // -------------------------------------------------------------------------
  logic [4:0]             rr_start;
  logic [NUM_MASTERS-1:0] req_rot;
  logic                   rr_found;
  logic [5:0]             rr_off;
  logic [5:0]             rr_sum;
  logic                   fp_found;
  logic [3:0]             fp_win;
  logic [3:0]             winner;

  // Rotating priority: rotate the request vector so that bit 0 corresponds
  // to owner+1. The owner itself lands in the last slot, so it can only
  // win again when nobody else is requesting.
  always_comb begin
    rr_start = {1'b0, owner} + 5'd1;
    req_rot  = NUM_MASTERS'({HBUSREQ, HBUSREQ} >> rr_start);
    rr_found = 1'b0;
    rr_off   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!rr_found && req_rot[k]) begin
        rr_found = 1'b1;
        rr_off   = 6'(k);
      end
    end
    // owner + 1 + offset is below 2*N, so a single wrap is enough.
    rr_sum = {2'b00, owner} + 6'd1 + rr_off;
    if (rr_sum >= 6'(NUM_MASTERS)) begin
      rr_sum = rr_sum - 6'(NUM_MASTERS);
    end
  end

  always_comb begin
    fp_found = 1'b0;
    fp_win   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!fp_found && HBUSREQ[k]) begin
        fp_found = 1'b1;
        fp_win   = 4'(k);
      end
    end
  end

  always_comb begin
    winner = DEF_CODE;
    if (ROUND_ROBIN != 0) begin
      if (rr_found) begin
        winner = rr_sum[3:0];
      end
    end else begin
      if (fp_found) begin
        winner = fp_win;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next state
  // -------------------------------------------------------------------------
  always_comb begin
    hgrant_d     = hgrant_q;
    hmaster_d    = hmaster_q;
    hmaster_dp_d = hmaster_dp_q;
    hmastlock_d  = hmastlock_q;
    if (rearb_ok) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        hgrant_d[i] = (winner == 4'(i));
      end
    end
    if (HREADY) begin
      hmaster_d    = owner;
      hmaster_dp_d = hmaster_q;
      hmastlock_d  = owner_lock;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hgrant_q     <= DEF_GRANT;
      hmaster_q    <= DEF_CODE;
      hmaster_dp_q <= DEF_CODE;
      hmastlock_q  <= 1'b0;
      beats_left_q <= '0;
    end else begin
      hgrant_q     <= hgrant_d;
      hmaster_q    <= hmaster_d;
      hmaster_dp_q <= hmaster_dp_d;
      hmastlock_q  <= hmastlock_d;
      beats_left_q <= beats_left_d;
    end
  end

  assign HGRANT    = hgrant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTER_D = hmaster_dp_q;
  assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter
//
// Two three-master arbiters share every input:
//   dut_rr  round-robin
//   dut_fp  fixed-priority
// Directed stimulus pushes the hand-computed arbiter state expected after
// each edge into a queue. A monitor on the falling edge pops the entries due
// and compares them with the selected instance.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter;

  localparam int N = 3;

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, WRAP4 = 3'd2, INCR4 = 3'd3, INCR8 = 3'd5, INCR16 = 3'd7;
  localparam logic [1:0] OKAY = 2'd0, RETRY = 2'd2;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic [N-1:0] HBUSREQ = '0;
  logic [N-1:0] HLOCK = '0;
  logic [1:0]   HTRANS = IDLE;
  logic [2:0]   HBURST = SINGLE;
  logic         HREADY = 1'b1;
  logic [1:0]   HRESP = OKAY;

  logic [N-1:0] hgrant_rr, hgrant_fp;
  logic [3:0]   hm_rr, hmd_rr, hm_fp, hmd_fp;
  logic         ml_rr, ml_fp;

  ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0), .ROUND_ROBIN(1)) dut_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
    .HGRANT(hgrant_rr), .HMASTER(hm_rr), .HMASTER_D(hmd_rr), .HMASTLOCK(ml_rr)
  );

  ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0), .ROUND_ROBIN(0)) dut_fp (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
    .HGRANT(hgrant_fp), .HMASTER(hm_fp), .HMASTER_D(hmd_fp), .HMASTLOCK(ml_fp)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    string        name;
    int           cyc;
    int           which;   // 0 = round-robin instance, 1 = fixed-priority
    logic [N-1:0] grant;
    logic [3:0]   hm;
    logic [3:0]   hmd;
    logic         ml;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // An all-x expected field is left unchecked.
  task automatic cmp4(input string nm, input string fld, input logic [3:0] got, input logic [3:0] want);
    if (!$isunknown(want)) begin
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s %s: got %0d want %0d", nm, fld, got, want);
      end
    end
  endtask

  task automatic check(input exp_t e, input logic [N-1:0] g, input logic [3:0] hm,
                       input logic [3:0] hmd, input logic ml);
    n_cmp++;
    if (g !== e.grant) begin
      n_bad++;
      $display("FAIL %s HGRANT: got %b want %b", e.name, g, e.grant);
    end
    cmp4(e.name, "HMASTER", hm, e.hm);
    cmp4(e.name, "HMASTER_D", hmd, e.hmd);
    cmp4(e.name, "HMASTLOCK", {3'b000, ml}, {3'b000, e.ml});
  endtask

  always @(negedge HCLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.which == 0) check(mon_e, hgrant_rr, hm_rr, hmd_rr, ml_rr);
      else                  check(mon_e, hgrant_fp, hm_fp, hmd_fp, ml_fp);
    end
  end

  task automatic drv(input logic [N-1:0] req, input logic [N-1:0] lk, input logic [1:0] tr,
                     input logic [2:0] bu, input logic rdy, input logic [1:0] rsp);
    HBUSREQ = req;
    HLOCK   = lk;
    HTRANS  = tr;
    HBURST  = bu;
    HREADY  = rdy;
    HRESP   = rsp;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic ex(input int which, input string nm, input logic [N-1:0] g,
                    input logic [3:0] hm, input logic [3:0] hmd, input logic ml);
    exp_t e;
    e.name  = nm;
    e.cyc   = cyc;
    e.which = which;
    e.grant = g;
    e.hm    = hm;
    e.hmd   = hmd;
    e.ml    = ml;
    sb.push_back(e);
  endtask

  task automatic stp(input string nm, input logic [N-1:0] g, input logic [3:0] hm,
                     input logic [3:0] hmd, input logic ml);
    tick();
    ex(0, nm, g, hm, hmd, ml);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three edges with no requests.
    drv(3'b000, 3'b000, IDLE, SINGLE, 1'b1, OKAY);
    repeat (3) begin
      tick();
      ex(0, "reset_rr", 3'b001, 4'd0, 4'd0, 1'b0);
      ex(1, "reset_fp", 3'b001, 4'd0, 4'd0, 1'b0);
    end
    HRESETn = 1'b1;
    stp("post_reset_idle", 3'b001, 4'd0, 4'd0, 1'b0);

    // Idle handoff to M1.
    drv(3'b010, 3'b000, IDLE, SINGLE, 1'b1, OKAY);
    stp("handoff_grant",   3'b010, 4'd0, 4'd0, 1'b0);
    stp("handoff_hmaster", 3'b010, 4'd1, 4'd0, 1'b0);
    stp("handoff_hmd",     3'b010, 4'd1, 4'd1, 1'b0);

    // Back to M0, then an INCR8 with M1 requesting from beat 3.
    drv(3'b001, 3'b000, IDLE, SINGLE, 1'b1, OKAY);
    stp("back_to_m0",   3'b001, 4'd1, 4'd1, 1'b0);
    stp("m0_idle",      3'b001, 4'd0, 4'd1, 1'b0);
    drv(3'b001, 3'b000, NONSEQ, INCR8, 1'b1, OKAY);
    stp("incr8_b1",     3'b001, 4'd0, 4'd0, 1'b0);
    drv(3'b001, 3'b000, SEQ, INCR8, 1'b1, OKAY);
    stp("incr8_b2",     3'b001, 4'd0, 4'd0, 1'b0);
    drv(3'b011, 3'b000, SEQ, INCR8, 1'b1, OKAY);
    for (int b = 3; b <= 7; b++) begin
      stp($sformatf("incr8_b%0d_hold", b), 3'b001, 4'd0, 4'd0, 1'b0);
    end
    stp("incr8_b8_handover", 3'b010, 4'd0, 4'd0, 1'b0);
    drv(3'b010, 3'b000, IDLE, INCR8, 1'b1, OKAY);
    stp("incr8_bubble", 3'b010, 4'd1, 4'd0, 1'b0);

    // M1 INCR4 with four wait states after beat 2; M2 waiting.
    drv(3'b110, 3'b000, NONSEQ, INCR4, 1'b1, OKAY);
    stp("incr4_b1", 3'b010, 4'd1, 4'd1, 1'b0);
    drv(3'b110, 3'b000, SEQ, INCR4, 1'b1, OKAY);
    stp("incr4_b2", 3'b010, 4'd1, 4'd1, 1'b0);
    drv(3'b110, 3'b000, SEQ, INCR4, 1'b0, OKAY);
    stp("wait_seq_1", 3'b010, 4'd1, 4'd1, 1'b0);
    stp("wait_seq_2", 3'b010, 4'd1, 4'd1, 1'b0);
    drv(3'b110, 3'b000, IDLE, INCR4, 1'b0, OKAY);
    stp("wait_idle_1", 3'b010, 4'd1, 4'd1, 1'b0);
    stp("wait_idle_2", 3'b010, 4'd1, 4'd1, 1'b0);
    drv(3'b110, 3'b000, SEQ, INCR4, 1'b1, OKAY);
    stp("incr4_b3",          3'b010, 4'd1, 4'd1, 1'b0);
    stp("incr4_b4_handover", 3'b100, 4'd1, 4'd1, 1'b0);

    // M1 locked with M0 and M2 requesting, then release.
    drv(3'b010, 3'b000, IDLE, SINGLE, 1'b1, OKAY);
    stp("to_m1",            3'b010, 4'd2, 4'd1, 1'b0);
    drv(3'b111, 3'b010, IDLE, SINGLE, 1'b1, OKAY);
    stp("lock_hold_1",      3'b010, 4'd1, 4'd2, 1'b1);
    stp("lock_hold_2",      3'b010, 4'd1, 4'd1, 1'b1);
    drv(3'b111, 3'b010, NONSEQ, SINGLE, 1'b1, OKAY);
    stp("lock_hold_single", 3'b010, 4'd1, 4'd1, 1'b1);
    drv(3'b101, 3'b000, IDLE, SINGLE, 1'b1, OKAY);
    stp("unlock_rr_m2",     3'b100, 4'd1, 4'd1, 1'b0);
    stp("unlock_rr_m0",     3'b001, 4'd2, 4'd1, 1'b0);

    // WRAP4 from M0: BUSY holds, RETRY re-arbitrates in its second cycle.
    drv(3'b001, 3'b000, IDLE, SINGLE, 1'b1, OKAY);
    stp("m0_settle",       3'b001, 4'd0, 4'd2, 1'b0);
    drv(3'b011, 3'b000, NONSEQ, WRAP4, 1'b1, OKAY);
    stp("wrap4_b1",        3'b001, 4'd0, 4'd0, 1'b0);
    drv(3'b011, 3'b000, BUSY, WRAP4, 1'b1, OKAY);
    stp("wrap4_busy_hold", 3'b001, 4'd0, 4'd0, 1'b0);
    drv(3'b011, 3'b000, SEQ, WRAP4, 1'b0, RETRY);
    stp("retry_cycle1",    3'b001, 4'd0, 4'd0, 1'b0);
    drv(3'b011, 3'b000, BUSY, WRAP4, 1'b1, RETRY);
    stp("retry_cycle2",    3'b010, 4'd0, 4'd0, 1'b0);

    // Reset asserted between edges during an INCR16 owned by M1.
    drv(3'b010, 3'b000, IDLE, SINGLE, 1'b1, OKAY);
    stp("pre_incr16", 3'b010, 4'd1, 4'd0, 1'b0);
    drv(3'b010, 3'b000, NONSEQ, INCR16, 1'b1, OKAY);
    stp("incr16_b1",  3'b010, 4'd1, 4'd1, 1'b0);
    drv(3'b010, 3'b000, SEQ, INCR16, 1'b1, OKAY);
    tick();
    HRESETn = 1'b0;
    ex(0, "async_reset_rr", 3'b001, 4'd0, 4'd0, 1'b0);
    ex(1, "async_reset_fp", 3'b001, 4'd0, 4'd0, 1'b0);
    drv(3'b011, 3'b000, IDLE, SINGLE, 1'b1, OKAY);
    tick();
    ex(0, "reset_hold_rr", 3'b001, 4'd0, 4'd0, 1'b0);
    ex(1, "reset_hold_fp", 3'b001, 4'd0, 4'd0, 1'b0);
    HRESETn = 1'b1;

    // M0 and M1 requesting: fixed priority keeps M0, round-robin alternates.
    tick();
    ex(1, "fp_e1", 3'b001, 4'd0, 4'd0, 1'b0);
    ex(0, "rr_e1", 3'b010, 4'd0, 4'd0, 1'b0);
    tick();
    ex(1, "fp_e2", 3'b001, 4'd0, 4'd0, 1'b0);
    ex(0, "rr_e2", 3'b001, 4'd1, 4'd0, 1'b0);
    tick();
    ex(1, "fp_e3", 3'b001, 4'd0, 4'd0, 1'b0);
    ex(0, "rr_e3", 3'b010, 4'd0, 4'd1, 1'b0);
    drv(3'b010, 3'b000, IDLE, SINGLE, 1'b1, OKAY);
    tick();
    ex(1, "fp_m1_only", 3'b010, 4'd0, 4'd0, 1'b0);
    ex(0, "rr_m1_only", 3'b010, 4'd1, 4'd0, 1'b0);
    drv(3'b011, 3'b000, IDLE, SINGLE, 1'b1, OKAY);
    tick();
    ex(1, "fp_lowest_wins", 3'b001, 4'd1, 4'd0, 1'b0);
    ex(0, "rr_to_m0",       3'b001, 4'd1, 4'd1, 1'b0);
    drv(3'b010, 3'b000, IDLE, SINGLE, 1'b1, OKAY);
    tick();
    ex(1, "fp_m1_again", 3'b010, 4'd0, 4'd1, 1'b0);
    ex(0, "rr_m1_again", 3'b010, 4'd0, 4'd1, 1'b0);
    drv(3'b000, 3'b000, IDLE, SINGLE, 1'b1, OKAY);
    tick();
    ex(1, "fp_default", 3'b001, 4'd1, 4'd0, 1'b0);
    ex(0, "rr_default", 3'b001, 4'd1, 4'd0, 1'b0);

    // Let the monitor drain the queue, with a bound.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge HCLK);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
